// File: rtl/sha_ctrl_pkg.sv
// Shared types and default sizing for the SHA-2 packet ID controller.
package sha_ctrl_pkg;

    localparam int unsigned DEF_ID_WIDTH      = 6;
    localparam int unsigned DEF_ID_DEPTH      = 4;
    localparam int unsigned DEF_CNT_WIDTH     = 3;
    localparam int unsigned DEF_PKT_CNT_WIDTH = 10;
    localparam int unsigned DEF_MAX_BLOCKS    = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/sha_packet_id_ctrl_if.sv
// Block-source, hash-engine and digest handshake bundle seen by the packet ID controller.
interface sha_packet_id_ctrl_if #(
    parameter int unsigned ID_WIDTH = sha_ctrl_pkg::DEF_ID_WIDTH
);
    logic                i_blk_valid;
    logic                i_blk_last;
    logic                o_blk_ready;
    logic                o_eng_valid;
    logic                i_eng_ready;
    logic [ID_WIDTH-1:0] o_eng_id;
    logic                i_dgst_valid;
    logic                i_dgst_ready;
    logic [ID_WIDTH-1:0] o_dgst_id;

    modport master (
        output i_blk_valid, i_blk_last, i_eng_ready, i_dgst_valid, i_dgst_ready,
        input  o_blk_ready, o_eng_valid, o_eng_id, o_dgst_id
    );

    modport slave (
        input  i_blk_valid, i_blk_last, i_eng_ready, i_dgst_valid, i_dgst_ready,
        output o_blk_ready, o_eng_valid, o_eng_id, o_dgst_id
    );
endinterface

// File: rtl/sha_id_fifo.sv
// In-order FIFO of outstanding packet IDs; head reads straight from registered storage.
module sha_id_fifo #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned WIDTH     = 6,
    parameter int unsigned CNT_WIDTH = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  logic [WIDTH-1:0]     i_data,
    output logic [WIDTH-1:0]     o_head,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic                 o_full,
    output logic                 o_empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign o_full    = (r_count == CNT_WIDTH'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_WIDTH'(1);
                2'b01:   r_count <= r_count - CNT_WIDTH'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/sha_packet_id_ctrl.sv
// Gates blocks into the SHA-2 engine, issues a packet ID per packet and tags digests in order.
module sha_packet_id_ctrl
    import sha_ctrl_pkg::*;
#(
    parameter int unsigned ID_WIDTH      = DEF_ID_WIDTH,
    parameter int unsigned ID_DEPTH      = DEF_ID_DEPTH,
    parameter int unsigned CNT_WIDTH     = DEF_CNT_WIDTH,
    parameter int unsigned PKT_CNT_WIDTH = DEF_PKT_CNT_WIDTH,
    parameter int unsigned MAX_BLOCKS    = DEF_MAX_BLOCKS
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    sha_packet_id_ctrl_if.slave      bus,
    input  logic                     i_status_err_clear,
    output logic [ID_WIDTH-1:0]      o_status_id,
    output logic [CNT_WIDTH-1:0]     o_status_buffered_ids,
    output logic                     o_status_err_buffer,
    output logic                     o_status_err_packet,
    output logic [PKT_CNT_WIDTH-1:0] o_status_packet_count
);
    localparam int unsigned BLK_W = $clog2(MAX_BLOCKS + 1);

    ctrl_state_e              r_state;
    ctrl_state_e              w_state_nxt;
    logic [ID_WIDTH-1:0]      r_next_id;
    logic [ID_WIDTH-1:0]      r_status_id;
    logic [BLK_W-1:0]         r_blk_cnt;
    logic                     r_err_buffer;
    logic                     r_err_packet;
    logic [PKT_CNT_WIDTH-1:0] r_pkt_cnt;

    logic                     w_gate;
    logic                     w_accept;
    logic                     w_push;
    logic                     w_cnt_inc;
    logic                     w_err_pkt_set;
    logic                     w_pop;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic [CNT_WIDTH-1:0]     w_fifo_count;
    logic [ID_WIDTH-1:0]      w_fifo_head;

    assign w_pop = bus.i_dgst_valid & bus.i_dgst_ready;

    sha_id_fifo #(
        .DEPTH     (ID_DEPTH),
        .WIDTH     (ID_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_id_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (r_next_id),
        .o_head  (w_fifo_head),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Gate uses the registered FIFO level, so a same-cycle pop never opens it.
    always_comb begin
        w_state_nxt   = r_state;
        w_gate        = 1'b0;
        w_accept      = 1'b0;
        w_push        = 1'b0;
        w_cnt_inc     = 1'b0;
        w_err_pkt_set = 1'b0;

        w_gate   = (r_state == IN_PKT) | ~w_fifo_full;
        w_accept = bus.i_blk_valid & bus.i_eng_ready & w_gate;

        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_push      = 1'b1;
                    w_state_nxt = bus.i_blk_last ? IDLE : IN_PKT;
                end
            end
            IN_PKT: begin
                if (w_accept) begin
                    if (bus.i_blk_last) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_inc     = 1'b1;
                        w_err_pkt_set = (r_blk_cnt == BLK_W'(MAX_BLOCKS - 1));
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ID issue, block counting, sticky errors (set beats clear) and completion count.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_next_id    <= '0;
            r_status_id  <= '0;
            r_blk_cnt    <= '0;
            r_err_buffer <= 1'b0;
            r_err_packet <= 1'b0;
            r_pkt_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_status_id <= r_next_id;
                r_next_id   <= r_next_id + ID_WIDTH'(1);
                r_blk_cnt   <= BLK_W'(1);
            end else if (w_cnt_inc && (r_blk_cnt != BLK_W'(MAX_BLOCKS))) begin
                r_blk_cnt <= r_blk_cnt + BLK_W'(1);
            end
            r_err_buffer <= (w_pop & w_fifo_empty) | (r_err_buffer & ~i_status_err_clear);
            r_err_packet <= w_err_pkt_set | (r_err_packet & ~i_status_err_clear);
            if (w_pop && !w_fifo_empty) begin
                r_pkt_cnt <= r_pkt_cnt + PKT_CNT_WIDTH'(1);
            end
        end
    end

    assign bus.o_eng_valid = bus.i_blk_valid & w_gate;
    assign bus.o_blk_ready = bus.i_eng_ready & w_gate;
    assign bus.o_eng_id    = (r_state == IDLE) ? r_next_id : r_status_id;
    assign bus.o_dgst_id   = w_fifo_head;

    assign o_status_id           = r_status_id;
    assign o_status_buffered_ids = w_fifo_count;
    assign o_status_err_buffer   = r_err_buffer;
    assign o_status_err_packet   = r_err_packet;
    assign o_status_packet_count = r_pkt_cnt;
endmodule

// File: tb/tb_sha_packet_id_ctrl.sv
// Randomized bench for sha_packet_id_ctrl checked against a queue-based packet/digest model.
module tb_sha_packet_id_ctrl;
    localparam int unsigned ID_WIDTH      = 6;
    localparam int unsigned ID_DEPTH      = 4;
    localparam int unsigned CNT_WIDTH     = 3;
    localparam int unsigned PKT_CNT_WIDTH = 10;
    localparam int unsigned MAX_BLOCKS    = 16;

    logic                     i_clk;
    logic                     i_rst_n;
    logic                     i_status_err_clear;
    logic [ID_WIDTH-1:0]      o_status_id;
    logic [CNT_WIDTH-1:0]     o_status_buffered_ids;
    logic                     o_status_err_buffer;
    logic                     o_status_err_packet;
    logic [PKT_CNT_WIDTH-1:0] o_status_packet_count;

    sha_packet_id_ctrl_if #(.ID_WIDTH(ID_WIDTH)) bus ();

    sha_packet_id_ctrl #(
        .ID_WIDTH      (ID_WIDTH),
        .ID_DEPTH      (ID_DEPTH),
        .CNT_WIDTH     (CNT_WIDTH),
        .PKT_CNT_WIDTH (PKT_CNT_WIDTH),
        .MAX_BLOCKS    (MAX_BLOCKS)
    ) dut (
        .i_clk                 (i_clk),
        .i_rst_n               (i_rst_n),
        .bus                   (bus),
        .i_status_err_clear    (i_status_err_clear),
        .o_status_id           (o_status_id),
        .o_status_buffered_ids (o_status_buffered_ids),
        .o_status_err_buffer   (o_status_err_buffer),
        .o_status_err_packet   (o_status_err_packet),
        .o_status_packet_count (o_status_packet_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: packet-level view of the controller.
    bit m_in_pkt;
    int m_next_id;
    int m_last_id;
    int m_blocks;
    int m_ids[$];
    bit m_err_buf;
    bit m_err_pkt;
    int m_done;
    int m_wraps_id;
    int m_wraps_cnt;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_pkt  = 1'b0;
        m_next_id = 0;
        m_last_id = 0;
        m_blocks  = 0;
        m_ids.delete();
        m_err_buf = 1'b0;
        m_err_pkt = 1'b0;
        m_done    = 0;
    endtask

    function automatic bit model_gate();
        return m_in_pkt || (m_ids.size() < int'(ID_DEPTH));
    endfunction

    task automatic model_step();
        bit gate;
        bit accept;
        bit pop;
        bit set_buf;
        bit set_pkt;
        if (!i_rst_n) begin
            model_reset();
            return;
        end
        gate    = model_gate();
        accept  = bus.i_blk_valid && bus.i_eng_ready && gate;
        pop     = bus.i_dgst_valid && bus.i_dgst_ready;
        set_buf = 1'b0;
        set_pkt = 1'b0;
        if (pop) begin
            if (m_ids.size() > 0) begin
                void'(m_ids.pop_front());
                if (m_done == (1 << PKT_CNT_WIDTH) - 1) m_wraps_cnt++;
                m_done = (m_done + 1) % (1 << PKT_CNT_WIDTH);
            end else begin
                set_buf = 1'b1;
            end
        end
        if (accept) begin
            if (!m_in_pkt) begin
                m_ids.push_back(m_next_id);
                m_last_id = m_next_id;
                if (m_next_id == (1 << ID_WIDTH) - 1) m_wraps_id++;
                m_next_id = (m_next_id + 1) % (1 << ID_WIDTH);
                m_blocks  = 1;
                m_in_pkt  = !bus.i_blk_last;
            end else if (bus.i_blk_last) begin
                m_in_pkt = 1'b0;
            end else begin
                if (m_blocks == int'(MAX_BLOCKS) - 1) set_pkt = 1'b1;
                if (m_blocks < int'(MAX_BLOCKS)) m_blocks++;
            end
        end
        m_err_buf = set_buf || (m_err_buf && !i_status_err_clear);
        m_err_pkt = set_pkt || (m_err_pkt && !i_status_err_clear);
    endtask

    task automatic check_status();
        check_val("status_id", 32'(o_status_id), 32'(m_last_id));
        check_val("buffered_ids", 32'(o_status_buffered_ids), 32'(m_ids.size()));
        check_val("err_buffer", 32'(o_status_err_buffer), 32'(m_err_buf));
        check_val("err_packet", 32'(o_status_err_packet), 32'(m_err_pkt));
        check_val("packet_count", 32'(o_status_packet_count), 32'(m_done));
    endtask

    task automatic check_comb();
        bit gate;
        gate = model_gate();
        check_val("eng_valid", 32'(bus.o_eng_valid), 32'(bus.i_blk_valid & gate));
        check_val("blk_ready", 32'(bus.o_blk_ready), 32'(bus.i_eng_ready & gate));
        check_val("eng_id", 32'(bus.o_eng_id), 32'(m_in_pkt ? m_last_id : m_next_id));
        check_val("dgst_id", 32'(bus.o_dgst_id), 32'((m_ids.size() > 0) ? m_ids[0] : 0));
    endtask

    function automatic bit pct(input int p);
        return $urandom_range(99) < p;
    endfunction

    // Percent probabilities per input; p_rst is per mille.
    task automatic run_phase(input int n, input int p_v, input int p_last, input int p_er,
                             input int p_dv, input int p_dr, input int p_clr, input int p_rst);
        for (int c = 0; c < n; c++) begin
            @(negedge i_clk);
            check_status();
            bus.i_blk_valid    = pct(p_v);
            bus.i_blk_last     = pct(p_last);
            bus.i_eng_ready    = pct(p_er);
            bus.i_dgst_valid   = pct(p_dv);
            bus.i_dgst_ready   = pct(p_dr);
            i_status_err_clear = pct(p_clr);
            i_rst_n            = !($urandom_range(999) < p_rst);
            #1;
            check_comb();
            @(posedge i_clk);
            model_step();
        end
    endtask

    initial begin
        m_wraps_id  = 0;
        m_wraps_cnt = 0;
        bus.i_blk_valid    = 1'b0;
        bus.i_blk_last     = 1'b0;
        bus.i_eng_ready    = 1'b0;
        bus.i_dgst_valid   = 1'b0;
        bus.i_dgst_ready   = 1'b0;
        i_status_err_clear = 1'b0;
        i_rst_n            = 1'b0;
        repeat (2) @(posedge i_clk);
        model_reset();
        i_rst_n = 1'b1;

        run_phase(1500, 70, 40, 80, 40, 70,  5, 0);   // mixed traffic
        run_phase(1500, 90, 50, 90, 10, 50,  3, 0);   // FIFO mostly full, blocked starts
        run_phase(1000, 10, 50, 80, 80, 80, 30, 0);   // underflow and clear races
        run_phase(1500, 90,  3, 90, 30, 90,  2, 0);   // long packets past MAX_BLOCKS
        run_phase(5000, 90, 60, 90, 60, 90,  1, 0);   // ID and packet-count wrap
        run_phase(1500, 80, 20, 80, 50, 80,  5, 5);   // resets landing mid-packet

        @(negedge i_clk);
        check_status();
        if (m_wraps_id == 0 || m_wraps_cnt == 0)
            $display("note: wrap coverage id=%0d cnt=%0d", m_wraps_id, m_wraps_cnt);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
